risc_v_mike_data_memory_bus: RTL and testbench
==============================================

Name: risc_v_mike_data_memory_bus

Overview:
- Second-generation data memory for the RISC-V Mike core: byte-addressed, parametrised depth and base address, with RV32 load/store sizing (SB/SH/SW, LB/LH/LW/LBU/LHU).
- Valid/ready request channel; registered response channel with error flag and backpressure.
- Sits between the core's memory stage and the data-side bus; replaces the single-cycle combinational-read word memory.

Parameters:
- DATA_MEM_DEPTH, 64, number of 32-bit words; must be a power of two, at least 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DATA_MEM_DEPTH*4.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid & req_ready.
- req_addr  input  DATA_32_W  byte address.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 funct3 size/sign code.
- req_wdata  input  DATA_32_W  store data; bytes taken from the LSBs.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  output  DATA_32_W  load result, extended per funct3; 0 for stores and errors.
- rsp_err  output  1  access error (out of range, misaligned, illegal funct3).

Behaviour:
- **Reset (rst low):**
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE.
  - Memory array has no reset; contents undefined after power-up.
  - Reset mid-operation drops any pending response; a store accepted in the same edge as reset assertion is not guaranteed.
- **FSM:**
  - Two states: IDLE (no response held) and RESP (response held).
  - req_ready = (state==IDLE) | rsp_ready (combinational, one-entry skid).
  - Accept in IDLE -> RESP.
  - In RESP with rsp_ready: if a new request is accepted, stay in RESP (back-to-back, one access per cycle sustained); otherwise go to IDLE.
  - In RESP without rsp_ready: hold rsp_rdata/rsp_err stable, req_ready=0.
- **Latency:** response valid exactly 1 cycle after acceptance. Stores write the array on the accepting edge and also produce a response (rdata=0).
- **Address decode:**
  - off = req_addr - BASE_ADDR; in range iff req_addr >= BASE_ADDR and off < DATA_MEM_DEPTH*4.
  - word index = off[..:2]; byte lane = off[1:0].
- **Sizes:**
  - funct3 000 = byte, 001 = half, 010 = word, 100 = byte unsigned, 101 = half unsigned.
  - 100/101 with req_write=1 are illegal, as are 011, 110 and 111.
  - Half requires off[0]=0; word requires off[1:0]=0 (see Optional Feature).
- **Stores:** byte-enable write of only the addressed lanes. SH at lane 2 writes bytes 2-3; all other bytes are unchanged.
- **Loads:** selected lane(s) shifted to the LSBs, then sign- or zero-extended to 32 bits.
- **Errors:** any error gives rsp_err=1, rsp_rdata=0, and no array write. Response timing is identical to a good access.
- **Ordering:** a read accepted the cycle after a store to the same word returns the new data. No read bypass is needed, since a single port gives at most one access per cycle.

Optional Feature:
- Macro: RISC_V_MIKE_DMEM_MISALIGN_ERR_EN.
- Defined: misaligned half/word accesses flag rsp_err=1, as above.
- Undefined:
  - Misaligned accesses are silently aligned (off[0] cleared for half, off[1:0] cleared for word) and complete without error.
  - Range and funct3 errors are still reported.

Decomposition:
- risc_v_mike_pkg gains:
  - enum dmem_size_e (LB/LH/LW/LBU/LHU funct3 codes);
  - enum dmem_state_e {DMEM_IDLE, DMEM_RESP};
  - constant DMEM_BYTES_PER_WORD=4.
- Sub-module risc_v_mike_dmem_lane_align: purely combinational.
  - Store side: funct3 + lane + wdata -> byte enables + lane-positioned write data.
  - Load side: funct3 + lane + word -> extended rdata.
  - Also flags misalign and illegal funct3.
- Top holds the FSM, range decode, array and response register.

Test Plan:
- SW 32'hDEADBEEF @0x10, then LW @0x10 -> one cycle later rsp_valid=1, rdata=32'hDEADBEEF, err=0.
- SB 8'h80 @0x13, then LB @0x13 -> 32'hFFFFFF80; LBU @0x13 -> 32'h00000080; LW @0x10 -> 32'h80ADBEEF.
- SH 16'h1234 @0x22, then LH @0x22 -> 32'h00001234. LW @0x20 shows upper half 16'h1234 and lower half unchanged.
- LW @DATA_MEM_DEPTH*4 (64 -> 0x100) -> err=1, rdata=0. A subsequent LW of previously written locations shows the memory unchanged.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and rsp stable. Then stream 8 loads with rsp_ready=1 -> 8 responses on 8 consecutive cycles, in order.
- LW @0x12 -> with macro: err=1. Without macro: returns the word at 0x10, err=0.
- Pulse rst low while a response is pending -> rsp_valid=0 immediately (asynchronously). After release, first request gets a normal response.

Source files
------------

// File: rtl/risc_v_mike_pkg.sv
// +--------------------------------------------------------------------------+
// | risc_v_mike_pkg                                                          |
// | Shared types and constants for the RISC-V Mike data memory.              |
// | Rev 2.0 - load/store sizing, valid/ready data memory bus                 |
// +--------------------------------------------------------------------------+
`default_nettype none

package risc_v_mike_pkg;

  localparam int DATA_32_W           = 32;
  localparam int DMEM_BYTES_PER_WORD = 4;

  // RV32 funct3 codes for loads/stores; the unsigned forms are load-only
  typedef enum logic [2:0] {
    DMEM_LB  = 3'b000,
    DMEM_LH  = 3'b001,
    DMEM_LW  = 3'b010,
    DMEM_LBU = 3'b100,
    DMEM_LHU = 3'b101
  } dmem_size_e;

  typedef enum logic [0:0] {
    DMEM_IDLE = 1'b0,
    DMEM_RESP = 1'b1
  } dmem_state_e;

endpackage

`default_nettype wire

// File: rtl/risc_v_mike_dmem_lane_align.sv
// +--------------------------------------------------------------------------+
// | risc_v_mike_dmem_lane_align                                              |
// | Combinational byte-lane steering for stores and extension for loads.     |
// | Rev 2.0 - initial sized-access version                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module risc_v_mike_dmem_lane_align
  import risc_v_mike_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic                 write,
  input  logic [1:0]           lane,
  input  logic [DATA_32_W-1:0] wdata,
  input  logic [DATA_32_W-1:0] rword,
  output logic [3:0]           be,
  output logic [DATA_32_W-1:0] wdata_pos,
  output logic [DATA_32_W-1:0] rdata,
  output logic                 misalign,
  output logic                 illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halves and words ignore the low lane bits, so a misaligned access lands
  // on the naturally aligned container; the top decides if that is an error.
  always_comb begin
    be        = 4'b0000;
    wdata_pos = wdata;
    rdata     = '0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    w_byte    = rword[{lane, 3'b000} +: 8];
    w_half    = lane[1] ? rword[31:16] : rword[15:0];
    case (dmem_size_e'(funct3))
      DMEM_LB, DMEM_LBU: begin
        illegal   = write & funct3[2];
        be        = 4'b0001 << lane;
        wdata_pos = {4{wdata[7:0]}};
        rdata     = {{24{w_byte[7] & ~funct3[2]}}, w_byte};
      end
      DMEM_LH, DMEM_LHU: begin
        illegal   = write & funct3[2];
        misalign  = lane[0];
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_pos = {2{wdata[15:0]}};
        rdata     = {{16{w_half[15] & ~funct3[2]}}, w_half};
      end
      DMEM_LW: begin
        misalign  = |lane;
        be        = 4'b1111;
        rdata     = rword;
      end
      default: begin
        illegal   = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/risc_v_mike_data_memory_bus.sv
// +--------------------------------------------------------------------------+
// | risc_v_mike_data_memory_bus                                              |
// | Byte-addressed data memory with valid/ready request and registered       |
// | response. Define RISC_V_MIKE_DMEM_MISALIGN_ERR_EN to flag misaligned     |
// | half/word accesses as errors instead of silently aligning them.          |
// | Rev 2.0 - replaces the combinational-read word memory                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module risc_v_mike_data_memory_bus
  import risc_v_mike_pkg::*;
#(
  parameter int                   DATA_MEM_DEPTH = 64,
  parameter logic [DATA_32_W-1:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DATA_32_W-1:0] req_addr,
  input  logic                 req_write,
  input  logic [2:0]           req_funct3,
  input  logic [DATA_32_W-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_32_W-1:0] rsp_rdata,
  output logic                 rsp_err
);

  localparam int                   c_WORD_IDX_W = $clog2(DATA_MEM_DEPTH);
  localparam logic [DATA_32_W-1:0] c_MEM_BYTES  =
    DATA_32_W'(DATA_MEM_DEPTH * DMEM_BYTES_PER_WORD);

`ifdef RISC_V_MIKE_DMEM_MISALIGN_ERR_EN
  localparam logic c_MISALIGN_ERR = 1'b1;
`else
  localparam logic c_MISALIGN_ERR = 1'b0;
`endif

  dmem_state_e          r_state;
  logic [DATA_32_W-1:0] r_rsp_rdata;
  logic                 r_rsp_err;
  logic [DATA_32_W-1:0] r_mem [DATA_MEM_DEPTH];

  logic [DATA_32_W-1:0]    w_off;
  logic                    w_in_range;
  logic [c_WORD_IDX_W-1:0] w_word_idx;
  logic [3:0]              w_be;
  logic [DATA_32_W-1:0]    w_wdata_pos;
  logic [DATA_32_W-1:0]    w_rdata_ext;
  logic                    w_misalign;
  logic                    w_illegal;
  logic                    w_err;
  logic                    w_accept;
  logic                    w_store;

  assign w_off      = req_addr - BASE_ADDR;
  assign w_in_range = (req_addr >= BASE_ADDR) && (w_off < c_MEM_BYTES);
  assign w_word_idx = w_off[c_WORD_IDX_W+1:2];

  risc_v_mike_dmem_lane_align u_lane_align (
    .funct3    (req_funct3),
    .write     (req_write),
    .lane      (w_off[1:0]),
    .wdata     (req_wdata),
    .rword     (r_mem[w_word_idx]),
    .be        (w_be),
    .wdata_pos (w_wdata_pos),
    .rdata     (w_rdata_ext),
    .misalign  (w_misalign),
    .illegal   (w_illegal)
  );

  assign w_err     = ~w_in_range | w_illegal | (c_MISALIGN_ERR & w_misalign);
  assign req_ready = (r_state == DMEM_IDLE) | rsp_ready;
  assign w_accept  = req_valid & req_ready;
  assign w_store   = w_accept & req_write & ~w_err;

  // Array is intentionally unreset; a load the cycle after a store sees the
  // new data because the write lands on the accepting edge.
  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int b = 0; b < DMEM_BYTES_PER_WORD; b++) begin
        if (w_be[b]) begin
          r_mem[w_word_idx][8*b +: 8] <= w_wdata_pos[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= DMEM_IDLE;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_state     <= DMEM_RESP;
      r_rsp_rdata <= (w_err | req_write) ? '0 : w_rdata_ext;
      r_rsp_err   <= w_err;
    end else if ((r_state == DMEM_RESP) && rsp_ready) begin
      r_state     <= DMEM_IDLE;
    end
  end

  assign rsp_valid = (r_state == DMEM_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_risc_v_mike_data_memory_bus.sv
// +--------------------------------------------------------------------------+
// | tb_risc_v_mike_data_memory_bus                                           |
// | Self-checking bench: byte-array reference model plus directed literals.  |
// | Rev 2.0 - initial bench                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_risc_v_mike_data_memory_bus;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] rd;
    bit          err;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl[NBYTES];

  risc_v_mike_data_memory_bus #(
    .DATA_MEM_DEPTH (DEPTH),
    .BASE_ADDR      (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Little-endian byte array model of one access; updates memory for stores.
  task automatic model_access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output bit err);
    longint off;
    longint val;
    int     n;
    bit     uns;
    bit     legal;
    bit     in_range;
    bit     misal;
    off   = longint'(a) - longint'(BASE);
    n     = 1;
    uns   = 1'b0;
    legal = 1'b1;
    case (f3)
      3'd0: n = 1;
      3'd1: n = 2;
      3'd2: n = 4;
      3'd4: begin n = 1; uns = 1'b1; legal = !wr; end
      3'd5: begin n = 2; uns = 1'b1; legal = !wr; end
      default: legal = 1'b0;
    endcase
    in_range = (off >= 0) && (off < NBYTES);
    misal    = (off % n) != 0;
`ifdef RISC_V_MIKE_DMEM_MISALIGN_ERR_EN
    err = !legal || !in_range || misal;
`else
    err = !legal || !in_range;
    off = off - (off % n);
`endif
    rd = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mdl[int'(off) + i] = wd[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < n; i++) val = val | (longint'(mdl[int'(off) + i]) << (8 * i));
        if (!uns && val[8*n-1]) val = val | ~((longint'(1) << (8 * n)) - 1);
        rd = val[31:0];
      end
    end
  endtask

  // Single compare process: outputs are checked against the model every cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] rd;
    bit          er;
    bit          pend;
    if (!rst) begin
      exp_q.delete();
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    end else begin
      pend = exp_q.size() != 0;
      chk("req_ready", 32'(req_ready), 32'(!pend || rsp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(pend));
      if (pend && rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_q[0].rd);
        chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
      end
      if (pend && rsp_ready) void'(exp_q.pop_front());
      if (req_valid && (!pend || rsp_ready)) begin
        model_access(req_write, req_funct3, req_addr, req_wdata, rd, er);
        e.rd  = rd;
        e.err = er;
        exp_q.push_back(e);
      end
    end
  end

  // Entered and left at posedge+1; one access, response checked against literals.
  task automatic lit_access(input string nm, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input bit exp_err);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rsp_ready  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_rdata"}, rsp_rdata, exp_rd);
    chk({nm, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit v, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  initial begin
    logic [31:0] ra;
    rst = 1'b0;
    set_req(1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Fill every word back-to-back so later loads have defined contents.
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1'b1, 1'b1, 3'd2, BASE + 32'(4 * i), $urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;

    lit_access("sw_10",  1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    lit_access("lw_10",  1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    lit_access("sb_13",  1'b1, 3'd0, 32'h13, 32'h12345680, 32'h0, 1'b0);
    lit_access("lb_13",  1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    lit_access("lbu_13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h00000080, 1'b0);
    lit_access("lw_10b", 1'b0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    lit_access("sw_20",  1'b1, 3'd2, 32'h20, 32'h55667788, 32'h0, 1'b0);
    lit_access("sh_22",  1'b1, 3'd1, 32'h22, 32'hABCD1234, 32'h0, 1'b0);
    lit_access("lh_22",  1'b0, 3'd1, 32'h22, 32'h0, 32'h00001234, 1'b0);
    lit_access("lw_20",  1'b0, 3'd2, 32'h20, 32'h0, 32'h12347788, 1'b0);
    lit_access("lh_neg", 1'b0, 3'd1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    lit_access("lw_oor", 1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1);
    lit_access("sw_oor", 1'b1, 3'd2, 32'h100, 32'h11111111, 32'h0, 1'b1);
    lit_access("lw_10c", 1'b0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    lit_access("lw_20b", 1'b0, 3'd2, 32'h20, 32'h0, 32'h12347788, 1'b0);
    lit_access("sbu_ill", 1'b1, 3'd4, 32'h10, 32'h0, 32'h0, 1'b1);
    lit_access("f3_011", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1);
`ifdef RISC_V_MIKE_DMEM_MISALIGN_ERR_EN
    lit_access("lw_12",  1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1);
`else
    lit_access("lw_12",  1'b0, 3'd2, 32'h12, 32'h0, 32'h80ADBEEF, 1'b0);
`endif

    // Backpressure: response held while req_valid stays high.
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h80ADBEEF);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 1'b0, 3'd2, BASE + 32'(4 * i), 32'h0);
      @(negedge clk);
      chk("stream_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset with a response pending.
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    rsp_ready = 1'b1;
    lit_access("post_rst", 1'b0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 9))
        0:       ra = BASE + 32'(NBYTES) + 32'($urandom_range(0, 15));
        1:       ra = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ra = BASE + 32'($urandom_range(0, NBYTES - 1));
      endcase
      set_req($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), ra, $urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
